fsm1_resp: RTL
==============

Name: fsm1_resp

Overview:
Read responder: the target side of the rd/ws/ds read handshake driven by the fsm1 family of initiators. It fetches one word per transaction from a req/ack backing store at an auto-incrementing address. It also inserts a programmable minimum number of wait states. It holds `ws` high until the word is ready, then presents it on `dout` with `ws` low until the initiator's `ds` closes the transfer.

Parameters:
DW  8  data width of dout and mem_rdata
AW  8  address width of mem_addr and addr_din
WW  4  width of wait_cfg

Ports:
clk        input   1   clock, all state updates on its rising edge
rst_n      input   1   asynchronous active-low reset
rd         input   1   read request from initiator, held high until transfer closes
ds         input   1   done strobe from initiator, one cycle, rd low in same cycle
wait_cfg   input   WW  minimum wait states for next transaction, sampled at accept
ws         output  1   wait: 1 = not ready, 0 = dout valid
dout       output  DW  read data, valid while ws=0
busy       output  1   1 whenever state != R_IDLE
mem_req    output  1   backing-store request, held until mem_ack
mem_addr   output  AW  backing-store address (current address counter)
mem_ack    input   1   backing-store acknowledge, mem_rdata valid same cycle
mem_rdata  input   DW  backing-store read data
addr_ld    input   1   load address counter from addr_din (honoured in R_IDLE only)
addr_din   input   AW  address load value

Behaviour:
- Reset values:
  - ws=1, dout=0, busy=0, mem_req=0, mem_addr=0
  - state=R_IDLE, wait counter=0, have_data=0
- All outputs are registered; no combinational path from any input to any output.
- R_IDLE:
  - ws=1.
  - addr_ld=1 loads mem_addr<=addr_din. It has priority over rd; rd is accepted on the next edge, because the initiator keeps rd high.
  - Otherwise rd=1 is accepted:
    - cnt<=wait_cfg
    - mem_req<=1, have_data<=0
    - state<=R_WAIT
- R_WAIT, evaluated at each edge:
  - If mem_req && mem_ack: dout<=mem_rdata, have_data<=1, mem_req<=0.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 and (have_data or mem_ack this edge): ws<=0, state<=R_READY.
  - Net effect: at least wait_cfg+1 cycles in R_WAIT, and never less than backing-store latency.
- R_READY:
  - ws=0, dout held stable.
  - On ds=1: ws<=1, mem_addr<=mem_addr+1 (wraps modulo 2**AW), state<=R_IDLE.
- Abort: rd=0 and ds=0 while in R_WAIT or R_READY (initiator reset):
  - ws<=1, no address increment.
  - If mem_req is still outstanding, go to R_DRAIN; otherwise go to R_IDLE.
- R_DRAIN:
  - ws=1, mem_req stays high until mem_ack.
  - On mem_ack: mem_req<=0, state<=R_IDLE; data is discarded and dout is unchanged.
  - rd is ignored in this state.
- Unreachable state encoding: ws<=1, mem_req<=0, state<=R_IDLE.
- addr_ld outside R_IDLE is ignored.
- wait_cfg changes after accept have no effect on the current transaction.
- ds seen in R_IDLE, R_WAIT or R_DRAIN is ignored (not an abort, since rd=0 with ds=1 is the normal close).
- Asynchronous reset mid-transaction returns everything to reset values immediately; mem_req drops, and the backing store must tolerate an abandoned request.
- Interaction with a registered initiator (rd high in READ/DLY, ws sampled in DLY):
  - ws=1 at the first DLY sample forces one extra READ/DLY loop.
  - Minimum transaction is therefore initiator go to ds in 4 cycles after rd rises.
  - ws=0 is held until ds, so a low ws seen during READ is harmless.

Test Plan:
1. Reset, then rd=1 with wait_cfg=0, mem_ack in the first R_WAIT cycle with mem_rdata=0xA5 -> ws falls 2 edges after rd rises, dout=0xA5 until ds, mem_addr goes 0->1 on ds, ws=1 after ds.
2. wait_cfg=3, mem_ack after 1 cycle -> exactly 4 cycles in R_WAIT, dout captured on the ack cycle and unchanged thereafter, ws=0 only after cnt reaches 0.
3. wait_cfg=0, mem_ack delayed 6 cycles -> mem_req high for 6 cycles, ws stays 1 until the edge of ack, then 0.
4. addr_ld=1 with addr_din=0xFF and rd=1 in the same R_IDLE cycle -> mem_addr=0xFF, transaction starts next edge; after ds mem_addr wraps to 0x00.
5. Back-to-back reads against a registered initiator with go held and mem_ack=1 constantly, mem_rdata=addr -> dout sequence 0,1,2,3, no ws glitch low while in R_IDLE.
6. rd dropped with ds=0 while mem_req pending, mem_ack 3 cycles later -> state R_DRAIN, mem_addr unchanged, dout unchanged, busy=0 after ack. Repeat with rst_n pulsed low mid-R_WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fsm1_resp_if.sv
`default_nettype none
// ============================================================================
// Module      : fsm1_resp_if
// Description : Read-handshake (rd/ws/ds) and backing-store (req/ack) signal
//               bundle for the fsm1 read responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface fsm1_resp_if #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int WW = 4
);
  // initiator side
  logic          rd;
  logic          ds;
  logic [WW-1:0] wait_cfg;
  logic          ws;
  logic [DW-1:0] dout;
  logic          busy;
  // backing-store side
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  // address counter load
  logic          addr_ld;
  logic [AW-1:0] addr_din;

  modport slave (
    input  rd, ds, wait_cfg, mem_ack, mem_rdata, addr_ld, addr_din,
    output ws, dout, busy, mem_req, mem_addr
  );

  modport master (
    output rd, ds, wait_cfg, mem_ack, mem_rdata, addr_ld, addr_din,
    input  ws, dout, busy, mem_req, mem_addr
  );
endinterface
`default_nettype wire

// File: rtl/fsm1_resp.sv
`default_nettype none
// ============================================================================
// Module      : fsm1_resp
// Description : Read responder for the rd/ws/ds handshake. Fetches one word
//               per transaction from a req/ack store at an auto-incrementing
//               address and enforces a programmable minimum wait count.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm1_resp #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int WW = 4
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  fsm1_resp_if.slave     bus
);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_READY = 2'd2,
    R_DRAIN = 2'd3
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [WW-1:0] r_cnt,      w_cnt_nxt;
  logic          r_have,     w_have_nxt;
  logic          r_ws,       w_ws_nxt;
  logic [DW-1:0] r_dout,     w_dout_nxt;
  logic          r_busy,     w_busy_nxt;
  logic          r_mem_req,  w_req_nxt;
  logic [AW-1:0] r_mem_addr, w_addr_nxt;

  logic w_ack_hit;
  logic w_abort;

  // An ack only counts while our own request is outstanding.
  assign w_ack_hit = r_mem_req && bus.mem_ack;
  // rd low without ds means the initiator was reset mid-transfer.
  assign w_abort   = !bus.rd && !bus.ds;

  assign bus.ws       = r_ws;
  assign bus.dout     = r_dout;
  assign bus.busy     = r_busy;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_have_nxt  = r_have;
    w_ws_nxt    = r_ws;
    w_dout_nxt  = r_dout;
    w_req_nxt   = r_mem_req;
    w_addr_nxt  = r_mem_addr;

    case (r_state)
      R_IDLE: begin
        w_ws_nxt = 1'b1;
        // A load wins over rd; rd stays high and is accepted next edge.
        if (bus.addr_ld) begin
          w_addr_nxt = bus.addr_din;
        end else if (bus.rd) begin
          w_cnt_nxt   = bus.wait_cfg;
          w_req_nxt   = 1'b1;
          w_have_nxt  = 1'b0;
          w_state_nxt = R_WAIT;
        end
      end

      R_WAIT: begin
        if (w_abort) begin
          w_ws_nxt = 1'b1;
          // A request acked on the abort edge is complete; no drain needed.
          if (r_mem_req && !bus.mem_ack) begin
            w_state_nxt = R_DRAIN;
          end else begin
            w_req_nxt   = 1'b0;
            w_state_nxt = R_IDLE;
          end
        end else begin
          if (w_ack_hit) begin
            w_dout_nxt = bus.mem_rdata;
            w_have_nxt = 1'b1;
            w_req_nxt  = 1'b0;
          end
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (r_have || w_ack_hit) begin
            w_ws_nxt    = 1'b0;
            w_state_nxt = R_READY;
          end
        end
      end

      R_READY: begin
        if (bus.ds) begin
          w_ws_nxt    = 1'b1;
          w_addr_nxt  = r_mem_addr + 1'b1;
          w_state_nxt = R_IDLE;
        end else if (w_abort) begin
          w_ws_nxt    = 1'b1;
          w_state_nxt = R_IDLE;
        end
      end

      R_DRAIN: begin
        // Wait out the abandoned fetch; its data is thrown away.
        w_ws_nxt = 1'b1;
        if (bus.mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = R_IDLE;
        end
      end

      default: begin
        w_ws_nxt    = 1'b1;
        w_req_nxt   = 1'b0;
        w_state_nxt = R_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != R_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      r_cnt      <= '0;
      r_have     <= 1'b0;
      r_ws       <= 1'b1;
      r_dout     <= '0;
      r_busy     <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_have     <= w_have_nxt;
      r_ws       <= w_ws_nxt;
      r_dout     <= w_dout_nxt;
      r_busy     <= w_busy_nxt;
      r_mem_req  <= w_req_nxt;
      r_mem_addr <= w_addr_nxt;
    end
  end

endmodule
`default_nettype wire
